// File: rtl/store_merge_pkg.sv
// -----------------------------------------------------------------------------
// store_merge_pkg
// Shared definitions for the store_merge block:
//   - size_e  : store size codes carried on req_size
//   - state_e : control FSM encoding (IDLE / RD / WR)
//   - is_misaligned() : alignment / reserved-size check used at accept time
// -----------------------------------------------------------------------------
package store_merge_pkg;

   typedef enum logic [1:0] {
      SZ_WORD = 2'b00,
      SZ_HALF = 2'b01,
      SZ_BYTE = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RD   = 2'b01,
      WR   = 2'b10
   } state_e;

   // A store raises an address error when the byte offset is not a multiple
   // of its size, or when the size code is the reserved one.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] lsb);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_WORD: bad = (lsb != 2'b00);
         SZ_HALF: bad = lsb[0];
         SZ_BYTE: bad = 1'b0;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/store_merge_byte_lane_merge.sv
// -----------------------------------------------------------------------------
// byte_lane_merge
// Combinational little-endian lane placement: overlays the low byte / half /
// full word of wdata onto old_word at the lanes selected by addr_lo and size.
// Bits outside the written lanes pass through from old_word unchanged.
//
// Ports:
//   old_word  in  32  word currently held in memory (or forwarded copy)
//   wdata     in  32  store source value
//   addr_lo   in  2   byte offset within the word
//   size      in  2   size code (see store_merge_pkg::size_e)
//   merged    out 32  word to be written back
// -----------------------------------------------------------------------------
module byte_lane_merge
   import store_merge_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   output logic [31:0] merged
);

   // NOTE: merged gets a full default before any partial overwrite, so every
   // path assigns it and no latch is inferred.
   always_comb begin
      merged = old_word;
      case (size)
         SZ_WORD: merged = wdata;
         SZ_HALF: begin
            if (addr_lo[1]) merged[31:16] = wdata[15:0];
            else            merged[15:0]  = wdata[15:0];
         end
         SZ_BYTE: begin
            case (addr_lo)
               2'd0: merged[7:0]   = wdata[7:0];
               2'd1: merged[15:8]  = wdata[7:0];
               2'd2: merged[23:16] = wdata[7:0];
               2'd3: merged[31:24] = wdata[7:0];
               default: ;
            endcase
         end
         default: ;  // reserved size never reaches a write
      endcase
   end

endmodule

// File: rtl/store_merge.sv
// -----------------------------------------------------------------------------
// store_merge
// Store-side sub-word write unit for a word-only data memory. Word stores are
// written directly; byte and half stores read the containing word, merge the
// new lanes and write it back. Misaligned or reserved-size stores pulse
// exc_ades and make no memory access.
//
// Optional feature (macro STORE_MERGE_FWD_EN): a one-entry last-write cache.
// A sub-word store hitting the cached word address skips the read and merges
// onto the cached word instead.
//
// Ports:
//   clk        in  1   rising-edge clock
//   reset      in  1   synchronous active-high reset
//   req_valid  in  1   store request present
//   req_ready  out 1   request can be accepted (IDLE only)
//   req_addr   in  32  byte address
//   req_wdata  in  32  store source value
//   req_size   in  2   00 word, 01 half, 10 byte, 11 reserved
//   done       out 1   pulse in the cycle the memory write is issued
//   exc_ades   out 1   pulse one cycle after accepting a bad store
//   mem_addr   out 32  word-aligned memory address, registered at accept
//   mem_rd_en  out 1   memory read strobe (data returns next cycle)
//   mem_rdata  in  32  memory read data
//   mem_wr_en  out 1   memory write strobe
//   mem_wdata  out 32  merged write word (0 outside write cycles)
// -----------------------------------------------------------------------------
module store_merge
   import store_merge_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   output logic        done,
   output logic        exc_ades,
   output logic [31:0] mem_addr,
   output logic        mem_rd_en,
   input  logic [31:0] mem_rdata,
   output logic        mem_wr_en,
   output logic [31:0] mem_wdata
);

   state_e      state_q, state_d;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [1:0]  size_q;
   logic        exc_q;

   logic        accept;
   logic        misaligned;
   logic        sub_word;
   logic        hit;
   logic [31:0] old_word;
   logic [31:0] merged;

   assign req_ready  = (state_q == IDLE);
   assign accept     = req_valid && req_ready;
   assign misaligned = is_misaligned(req_size, req_addr[1:0]);
   assign sub_word   = (req_size == SZ_HALF) || (req_size == SZ_BYTE);

`ifdef STORE_MERGE_FWD_EN
   logic        cache_valid;
   logic [29:0] cache_addr;
   logic [31:0] cache_data;
   logic        hit_q;      // current WR merges onto the cached word

   assign hit      = cache_valid && (cache_addr == req_addr[31:2]);
   assign old_word = hit_q ? cache_data : mem_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         cache_valid <= 1'b0;
         hit_q       <= 1'b0;
      end else begin
         hit_q <= accept && hit;
         if (state_q == WR) cache_valid <= 1'b1;
      end
   end

   // NOTE: the cached address/data need no reset; cache_valid alone decides
   // whether they are ever looked at.
   always_ff @(posedge clk) begin
      if (state_q == WR && !reset) begin
         cache_addr <= addr_q[31:2];
         cache_data <= merged;
      end
   end
`else
   assign hit      = 1'b0;
   assign old_word = mem_rdata;
`endif

   byte_lane_merge u_merge (
      .old_word (old_word),
      .wdata    (wdata_q),
      .addr_lo  (addr_q[1:0]),
      .size     (size_q),
      .merged   (merged)
   );

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            // Bad stores are reported via exc_q and leave the FSM in IDLE.
            if (accept && !misaligned) begin
               if (sub_word && !hit) state_d = RD;
               else                  state_d = WR;
            end
         end
         RD:      state_d = WR;
         WR:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
      done      = 1'b0;
      mem_wdata = 32'h0;
      case (state_q)
         RD: mem_rd_en = 1'b1;
         WR: begin
            mem_wr_en = 1'b1;
            done      = 1'b1;
            mem_wdata = merged;
         end
         default: ;
      endcase
   end

   assign exc_ades = exc_q;
   assign mem_addr = {addr_q[31:2], 2'b00};

   // NOTE: all state is updated with non-blocking assignments so every
   // register samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         size_q  <= SZ_WORD;
         exc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         exc_q   <= accept && misaligned;
         if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
         end
      end
   end

endmodule

// File: tb/tb_store_merge.sv
// -----------------------------------------------------------------------------
// tb_store_merge
// Directed self-checking bench for store_merge. Inputs are driven and outputs
// sampled on the falling clock edge. mem_rdata is held at a junk value except
// in the write cycle, where it carries the old word of the current store.
// -----------------------------------------------------------------------------
module tb_store_merge;

   localparam logic [31:0] JUNK = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        done;
   logic        exc_ades;
   logic [31:0] mem_addr;
   logic        mem_rd_en;
   logic [31:0] mem_rdata;
   logic        mem_wr_en;
   logic [31:0] mem_wdata;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   store_merge dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_size  (req_size),
      .done      (done),
      .exc_ades  (exc_ades),
      .mem_addr  (mem_addr),
      .mem_rd_en (mem_rd_en),
      .mem_rdata (mem_rdata),
      .mem_wr_en (mem_wr_en),
      .mem_wdata (mem_wdata)
   );

   // Leaves the caller at a falling edge with reset released.
   task automatic apply_reset;
      reset     = 1'b1;
      req_valid = 1'b0;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      req_size  = 2'b00;
      mem_rdata = JUNK;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Presents one request for a single edge; returns in cycle t+1.
   task automatic issue(input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] s);
      req_addr  = a;
      req_wdata = d;
      req_size  = s;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      req_valid = 1'b0;
      mem_rdata = JUNK;
      repeat (2) @(negedge clk);
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
      n_checks++; if (exc_ades !== 1'b0) begin n_fail++; $display("FAIL reset_exc got=%b exp=0", exc_ades); end
      n_checks++; if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd got=%b exp=0", mem_rd_en); end
      n_checks++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr got=%b exp=0", mem_wr_en); end
      n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
      n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
      reset = 1'b0;
   endtask

   task automatic test_word;
      apply_reset();
      issue(32'h0000_0100, 32'hDEAD_BEEF, 2'b00);
      n_checks++; if (mem_wr_en !== 1'b1) begin n_fail++; $display("FAIL word_wr got=%b exp=1", mem_wr_en); end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL word_done got=%b exp=1", done); end
      n_checks++; if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL word_rd got=%b exp=0", mem_rd_en); end
      n_checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL word_wdata got=%h exp=deadbeef", mem_wdata); end
      n_checks++; if (mem_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL word_addr got=%h exp=00000100", mem_addr); end
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL word_busy got=%b exp=0", req_ready); end
      @(negedge clk);
      n_checks++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL word_wr_end got=%b exp=0", mem_wr_en); end
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL word_ready_end got=%b exp=1", req_ready); end
   endtask

   // One sub-word store through the read path, starting from reset so no
   // forwarded copy can exist.
   task automatic test_subword(input string nm, input logic [31:0] a,
                               input logic [31:0] d, input logic [1:0] s,
                               input logic [31:0] old, input logic [31:0] exp_w);
      logic [31:0] exp_a;
      exp_a = {a[31:2], 2'b00};
      apply_reset();
      issue(a, d, s);
      n_checks++; if (mem_rd_en !== 1'b1) begin n_fail++; $display("FAIL %s_rd got=%b exp=1", nm, mem_rd_en); end
      n_checks++; if (mem_wr_en !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL %s_early_wr got wr=%b done=%b exp=0", nm, mem_wr_en, done); end
      n_checks++; if (mem_addr !== exp_a) begin n_fail++; $display("FAIL %s_addr got=%h exp=%h", nm, mem_addr, exp_a); end
      mem_rdata = old;
      @(negedge clk);
      n_checks++; if (mem_wr_en !== 1'b1 || done !== 1'b1) begin n_fail++; $display("FAIL %s_wr got wr=%b done=%b exp=1", nm, mem_wr_en, done); end
      n_checks++; if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL %s_rd_end got=%b exp=0", nm, mem_rd_en); end
      n_checks++; if (mem_wdata !== exp_w) begin n_fail++; $display("FAIL %s_wdata got=%h exp=%h", nm, mem_wdata, exp_w); end
      mem_rdata = JUNK;
      @(negedge clk);
      n_checks++; if (req_ready !== 1'b1 || mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL %s_idle got ready=%b wr=%b exp 1/0", nm, req_ready, mem_wr_en); end
   endtask

   task automatic test_misaligned;
      logic [31:0] addrs [3];
      logic [1:0]  sizes [3];
      addrs = '{32'h0000_0101, 32'h0000_0102, 32'h0000_0100};
      sizes = '{2'b01, 2'b00, 2'b11};
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         if (i < 3) begin
            req_addr  = addrs[i];
            req_size  = sizes[i];
            req_wdata = 32'h1234_5678;
            req_valid = 1'b1;
         end else begin
            req_valid = 1'b0;
         end
         @(negedge clk);
         n_checks++; if (exc_ades !== (i < 3)) begin n_fail++; $display("FAIL misalign_exc[%0d] got=%b exp=%b", i, exc_ades, (i < 3)); end
         n_checks++; if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL misalign_mem[%0d] got rd=%b wr=%b exp=0", i, mem_rd_en, mem_wr_en); end
         n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL misalign_ready[%0d] got=%b exp=1", i, req_ready); end
      end
   endtask

   task automatic test_reset_in_rd;
      apply_reset();
      issue(32'h0000_0100, 32'h0000_00AB, 2'b10);
      n_checks++; if (mem_rd_en !== 1'b1) begin n_fail++; $display("FAIL rstrd_rd got=%b exp=1", mem_rd_en); end
      reset     = 1'b1;
      mem_rdata = 32'h1122_3344;
      @(negedge clk);
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstrd_ready got=%b exp=1", req_ready); end
      n_checks++; if (mem_wr_en !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rstrd_wr got wr=%b done=%b exp=0", mem_wr_en, done); end
      reset     = 1'b0;
      mem_rdata = JUNK;
      @(negedge clk);
      n_checks++; if (mem_wr_en !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rstrd_wr_late got wr=%b done=%b exp=0", mem_wr_en, done); end
   endtask

   // req_valid held high: the second request waits out WR and is taken the
   // cycle after.
   task automatic test_back_to_back;
      apply_reset();
      req_addr  = 32'h0000_0400;
      req_wdata = 32'h1111_1111;
      req_size  = 2'b00;
      req_valid = 1'b1;
      @(negedge clk);
      n_checks++; if (mem_wr_en !== 1'b1 || mem_wdata !== 32'h1111_1111) begin n_fail++; $display("FAIL b2b_first got wr=%b data=%h exp 1/11111111", mem_wr_en, mem_wdata); end
      req_addr  = 32'h0000_0404;
      req_wdata = 32'h2222_2222;
      @(negedge clk);
      n_checks++; if (req_ready !== 1'b1 || mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got ready=%b wr=%b exp 1/0", req_ready, mem_wr_en); end
      @(negedge clk);
      req_valid = 1'b0;
      n_checks++; if (mem_wr_en !== 1'b1 || mem_wdata !== 32'h2222_2222) begin n_fail++; $display("FAIL b2b_second got wr=%b data=%h exp 1/22222222", mem_wr_en, mem_wdata); end
      n_checks++; if (mem_addr !== 32'h0000_0404) begin n_fail++; $display("FAIL b2b_addr got=%h exp=00000404", mem_addr); end
      @(negedge clk);
      n_checks++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL b2b_end got=%b exp=0", mem_wr_en); end
   endtask

   // Two byte stores to the same word. With forwarding the second skips the
   // read; without it, memory returns the first store's result.
   task automatic test_forward;
      apply_reset();
      issue(32'h0000_0300, 32'h0000_0055, 2'b10);
      mem_rdata = 32'h0;
      @(negedge clk);
      n_checks++; if (mem_wdata !== 32'h0000_0055) begin n_fail++; $display("FAIL fwd_first got=%h exp=00000055", mem_wdata); end
      mem_rdata = JUNK;
      @(negedge clk);
      issue(32'h0000_0301, 32'h0000_0066, 2'b10);
`ifdef STORE_MERGE_FWD_EN
      n_checks++; if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL fwd_noread got=%b exp=0", mem_rd_en); end
      n_checks++; if (mem_wr_en !== 1'b1 || mem_wdata !== 32'h0000_6655) begin n_fail++; $display("FAIL fwd_second got wr=%b data=%h exp 1/00006655", mem_wr_en, mem_wdata); end
`else
      n_checks++; if (mem_rd_en !== 1'b1) begin n_fail++; $display("FAIL fwd_read got=%b exp=1", mem_rd_en); end
      mem_rdata = 32'h0000_0055;
      @(negedge clk);
      n_checks++; if (mem_wr_en !== 1'b1 || mem_wdata !== 32'h0000_6655) begin n_fail++; $display("FAIL fwd_second got wr=%b data=%h exp 1/00006655", mem_wr_en, mem_wdata); end
      mem_rdata = JUNK;
`endif
      @(negedge clk);
      n_checks++; if (mem_wr_en !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL fwd_end got wr=%b ready=%b exp 0/1", mem_wr_en, req_ready); end
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      req_size  = 2'b00;
      mem_rdata = JUNK;
      test_reset();
      test_word();
      test_subword("byte3", 32'h0000_0103, 32'h0000_00AB, 2'b10, 32'h1122_3344, 32'hAB22_3344);
      test_subword("byte1", 32'h0000_0101, 32'h1234_5677, 2'b10, 32'h1122_3344, 32'h1122_7744);
      test_subword("half_hi", 32'h0000_0202, 32'h0000_CAFE, 2'b01, 32'h1122_3344, 32'hCAFE_3344);
      test_subword("half_lo", 32'h0000_0200, 32'h9999_BEEF, 2'b01, 32'h1122_3344, 32'h1122_BEEF);
      test_misaligned();
      test_reset_in_rd();
      test_back_to_back();
      test_forward();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/store_merge.md
# store_merge

Store-side sub-word write unit: the narrowing counterpart of the immediate/data extender. It accepts a store request of byte, halfword or word size and computes the little-endian byte lane placement. Because the data memory has no byte enables, it performs a read-modify-write to produce the full 32-bit word. It sits between the MEM stage store path and the word-only data memory, and raises an address-error flag for misaligned stores.

## Interface
Parameters:
- None. All widths are fixed at 32-bit data and 32-bit byte address.

Ports:
- clk  in  1  system clock; everything samples on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_addr  in  32  byte address.
- req_wdata  in  32  source register value; only the low 8 or 16 bits are used for byte or half stores.
- req_size  in  2  store size: 00 word, 01 half, 10 byte, 11 reserved.
- done  out  1  one-cycle pulse in the cycle the memory write is issued.
- exc_ades  out  1  one-cycle pulse marking a misaligned or reserved-size store.
- mem_addr  out  32  word address {addr[31:2],2'b00}, registered at accept.
- mem_rd_en  out  1  memory read strobe; mem_rdata is valid the following cycle.
- mem_rdata  in  32  memory read data.
- mem_wr_en  out  1  memory write strobe.
- mem_wdata  out  32  merged write word.

## Operation
- A request is accepted when req_valid && req_ready. On accept, addr, wdata and size are captured into registers.
- Misaligned cases:
  - half with addr[0]=1, word with addr[1:0]≠0, or size 11.
  - Response: exc_ades pulses in the next cycle, no memory access is made, and the unit stays in IDLE.
- FSM states: IDLE, RD, WR.
- Transitions:
  - IDLE → WR on accepting an aligned word store.
  - IDLE → RD on accepting an aligned half or byte store.
  - RD → WR unconditionally.
  - WR → IDLE unconditionally.
- Outputs per state:
  - RD: mem_rd_en=1.
  - WR: mem_wr_en=1 and done=1.
- Merge rule (little-endian), with the old word taken from mem_rdata in the WR cycle:
  - byte: lane k=addr[1:0]; bits [8k+7:8k] ← wdata[7:0].
  - half: addr[1]=0 → bits [15:0] ← wdata[15:0]; addr[1]=1 → bits [31:16] ← wdata[15:0].
  - word: mem_wdata = wdata.
  - All other bits are taken from the old word unchanged.
- This unit is the sole writer of data memory.

## Timing
- Reset values:
  - State is IDLE, so req_ready=1.
  - done, exc_ades, mem_rd_en and mem_wr_en are 0.
  - mem_addr and mem_wdata are 0.
- Latency from the accept cycle t:
  - word store: write and done at t+1.
  - sub-word store: read at t+1, write and done at t+2.
  - misaligned store: exc_ades at t+1.
- req_ready is low during RD and WR. A new request can be accepted in the cycle after WR.
- Back-to-back misaligned requests are accepted every cycle, with one exc_ades pulse per request.
- Reset asserted in RD or WR: returns to IDLE at the next edge. No write is issued that edge and done is not pulsed.
- req_valid dropping after accept has no effect, since the request is already registered.

## Configuration
- STORE_MERGE_FWD_EN, when defined:
  - The unit keeps a last-write cache: word address, merged word, and a valid bit (cleared by reset).
  - An aligned sub-word store whose word address matches a valid cache entry goes IDLE → WR directly, merging onto the cached word instead of mem_rdata. Latency is then t+1.
  - Every write, word stores included, updates the cache.
- When undefined: there is no cache and every sub-word store takes the RD path.

## Structure
- Package store_merge_pkg holds:
  - size codes SZ_WORD, SZ_HALF, SZ_BYTE, SZ_RSVD;
  - the state encoding IDLE/RD/WR.
- Sub-module byte_lane_merge (combinational):
  - inputs: old word, wdata, addr[1:0], size;
  - output: merged word;
  - shared by both the mem_rdata path and the cache path.

## Test plan
- Word store: addr 0x100, wdata 0xDEADBEEF → mem_wr_en and done at t+1; mem_wdata 0xDEADBEEF, mem_addr 0x100, no read.
- Byte store: addr 0x103, wdata 0x000000AB, mem_rdata 0x11223344 → read at t+1, write at t+2 with mem_wdata 0xAB223344.
- Half store: addr 0x202, wdata 0x0000CAFE, mem_rdata 0x11223344 → mem_wdata 0xCAFE3344, mem_addr 0x200.
- Misaligned: half at 0x101, word at 0x102, size 11 → exc_ades each, mem_rd_en and mem_wr_en never asserted.
- Reset asserted during RD → next cycle in IDLE, req_ready=1, no mem_wr_en and no done.
- With STORE_MERGE_FWD_EN: byte 0x300 ← 0x55, then byte 0x301 ← 0x66 (old word 0) → second store writes at t+1 with mem_wdata 0x00006655 and no read.
